mr_control_unit: RTL and testbench
==================================

# mr_control_unit

Moore-style control unit for the Maquina Rudimentaria CPU. It sequences the existing datapath (MEM, IR, PC, RDIR, REGB, RA, ALU, RZ/RN/RV) through fetch, decode and execute for the four instruction classes (load, store, ALU, branch). It drives every datapath control strobe from the current state, the IR contents and the stored flags. It sits beside the datapath inside `cpu` and replaces the free-standing control `reg`s.

## Interface
- No parameters; widths fixed by the 16-bit instruction and 8-bit address.
- `clk` input 1: single system clock; all state changes on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `en` input 1: run enable; 0 freezes the sequencer.
- `ir` input 16: current IR contents (`ir_out`).
- `rz`, `rn`, `rv` inputs 1 each: stored flags from RZ/RN/RV.
- `ld_ir`, `ld_rdir`, `ld_pc`, `mux_1_pc`, `reset_pc_sel`, `mem_w`, `erd`, `ld_ra`, `operar_alu`, `ld_rz`, `ld_rn`, `ld_rv` outputs 1 each: datapath controls, same meaning as the `cpu` signals of the same name (`erd` = Erd).
- `sel_rf` output 2: SELREG select (00 = IR[13:11], 01 = IR[10:8], 10 = IR[7:5]).
- `instr_done` output 1: one-cycle pulse when an instruction retires.
- `instr_count` output 16: retired-instruction counter.
- `state` output 3: current state, for debug.

## Operation
- Opcode is IR[15:14]: 00 LOAD, 01 STORE, 10 BRANCH, 11 ALU.
- For ALU instructions, IR[2] selects register (1) or immediate (0) operand B.
- States and encoding: RST=0, FETCH=1, DECODE=2, LOAD=3, STORE=4, ALU=5, FETCH_BR=6.
- Encodings 7 and above are illegal and go to RST.
- **RST:** `reset_pc_sel`=1, `ld_pc`=1 (PC←0). Next state is FETCH.
- **FETCH:** `mux_1_pc`=0, `ld_ir`=1, `ld_pc`=1 (IR←MEM[PC], PC←PC+1). Next state is DECODE.
- **DECODE:** `sel_rf`=01, `ld_rdir`=1 (RDIR←R[IR10:8]+IR[7:0]), `ld_ra`=1 (RA←R[IR10:8]).
  - Next state: LOAD, STORE or ALU by opcode.
  - BRANCH taken goes to FETCH_BR; BRANCH not taken goes to FETCH.
- **LOAD:** `mux_1_pc`=1, `operar_alu`=0 (B passthrough), `erd`=1, `ld_rz`=1, `ld_rn`=1. Next state is FETCH.
- **STORE:** `mux_1_pc`=1, `sel_rf`=00, `mem_w`=1 (MEM[RDIR]←R[IR13:11]). Next state is FETCH.
- **ALU:** `sel_rf`=10, `operar_alu`=1, `erd`=1, `ld_rz`=1, `ld_rn`=1, `ld_rv`=1. Next state is FETCH.
- **FETCH_BR:** `mux_1_pc`=1, `ld_ir`=1, `ld_pc`=1 (IR←MEM[RDIR], PC←RDIR+1). Next state is DECODE.
- Branch condition is taken from IR[13:11]:
  - 000 always; 001 Z; 010 N; 011 N|Z.
  - 100 never; 101 !Z; 110 !N; 111 !(N|Z).
  - `rv` is unused by branches.
- Any output not listed for a state is 0; `sel_rf` defaults to 01.
- `en`=0:
  - State holds.
  - `ld_ir`, `ld_rdir`, `ld_pc`, `mem_w`, `erd`, `ld_ra`, `ld_rz`, `ld_rn`, `ld_rv` and `instr_done` are forced to 0.
  - Mux selects keep their state values.
- `instr_done`=en in LOAD, STORE and ALU, and in DECODE when opcode=10.
- `instr_count` increments by 1 on every cycle with `instr_done`=1 and wraps from 0xFFFF to 0x0000.

## Timing
- Asynchronous reset (`rst_n`=0) immediately forces:
  - `state`=RST and `instr_count`=0.
  - `reset_pc_sel`=1 and all other outputs 0; `ld_pc` is gated by `rst_n`.
- The first rising edge with `rst_n`=1 and `en`=1 executes RST, so PC←0. FETCH of address 0 happens on the next edge.
- Cycles per instruction: LOAD, STORE and ALU take 3; branch not taken takes 2.
- Branch taken takes 2, plus FETCH_BR, which replaces the target's FETCH. The target instruction then needs only DECODE plus execute.
- The branch decision uses `rz`/`rn` as sampled in DECODE. Flags written by the immediately preceding LOAD or ALU are already visible, since they were registered at the end of that instruction.
- All outputs are combinational from `state`, `ir`, the flags and `en`; there is no output register.
- The datapath registers capture on the same edge that leaves the state.
- `rst_n` asserted mid-instruction (e.g. in STORE) deasserts `mem_w` asynchronously. No partial write may occur after reset assertion.
- `en` toggling mid-instruction resumes in the same state with no skipped or repeated strobes.

## Test plan
- **Reset, then run `en`=1:**
  - `state` goes 0→1→2.
  - In the RST cycle, `reset_pc_sel`=1 and `ld_pc`=1.
  - In FETCH, `mux_1_pc`=0, `ld_ir`=1, `ld_pc`=1.
- **LOAD, IR=0x0A05 (opcode 00):**
  - DECODE has `sel_rf`=01, `ld_rdir`=1, `ld_ra`=1.
  - LOAD has `mux_1_pc`=1, `erd`=1, `ld_rz`=`ld_rn`=1, `ld_rv`=0.
  - `instr_done` pulses once and `instr_count`=1.
- **STORE, IR=0x4A05:**
  - STORE cycle has `mem_w`=1, `sel_rf`=00, `mux_1_pc`=1, and `erd`=0.
  - Back in FETCH after 3 cycles.
- **ALU register, IR=0xC044:**
  - ALU cycle has `sel_rf`=10, `operar_alu`=1, `erd`=1 and all three flag loads =1.
- **Branches:**
  - BEQ, IR=0x8810, with `rz`=1: DECODE→FETCH_BR with `mux_1_pc`=1, `ld_ir`=1, `ld_pc`=1.
  - Same IR with `rz`=0: DECODE→FETCH.
  - IR=0xA010 (cond 100): never taken.
- **Stall, reset and counter wrap:**
  - `en`=0 held 3 cycles in ALU: state stays 5 with all strobes 0; resumes with a single `erd` pulse.
  - `rst_n`=0 during STORE: `mem_w` drops without waiting for a clock edge and `state`=0.
  - Preload 0xFFFF retirements: `instr_count` wraps to 0.

Source files
------------

// File: rtl/mr_control_unit.sv
// mr_control_unit: Moore sequencer for the Maquina Rudimentaria CPU.
// Drives the datapath strobes for fetch, decode and execute of
// LOAD, STORE, ALU and BRANCH instructions, and counts retirements.
module mr_control_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] ir,
    input  logic        rz,
    input  logic        rn,
    input  logic        rv,
    output logic        ld_ir,
    output logic        ld_rdir,
    output logic        ld_pc,
    output logic        mux_1_pc,
    output logic        reset_pc_sel,
    output logic        mem_w,
    output logic        erd,
    output logic        ld_ra,
    output logic        operar_alu,
    output logic        ld_rz,
    output logic        ld_rn,
    output logic        ld_rv,
    output logic [1:0]  sel_rf,
    output logic        instr_done,
    output logic [15:0] instr_count,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_RST      = 3'd0,
        S_FETCH    = 3'd1,
        S_DECODE   = 3'd2,
        S_LOAD     = 3'd3,
        S_STORE    = 3'd4,
        S_ALU      = 3'd5,
        S_FETCH_BR = 3'd6
    } state_t;

    localparam logic [1:0] OP_LOAD   = 2'b00;
    localparam logic [1:0] OP_STORE  = 2'b01;
    localparam logic [1:0] OP_BRANCH = 2'b10;

    state_t     cur_state;
    state_t     nxt_state;
    logic [1:0] opcode;
    logic       cond_base;
    logic       br_taken;

    // Ungated strobes; the write/load strobes are qualified by en below.
    logic ld_ir_raw, ld_rdir_raw, ld_pc_raw, mem_w_raw, erd_raw, ld_ra_raw;
    logic ld_rz_raw, ld_rn_raw, ld_rv_raw, done_raw;

    // Operand B mode, register fields and immediates belong to the datapath;
    // rv is only consumed by the flag registers, never by branches.
    logic unused_inputs;
    assign unused_inputs = ^{ir[10:0], rv};

    assign opcode = ir[15:14];
    assign state  = cur_state;

    // Branch condition: IR[12:11] picks always/Z/N/N|Z, IR[13] inverts it.
    always_comb begin
        cond_base = 1'b1;
        case (ir[12:11])
            2'b00:   cond_base = 1'b1;
            2'b01:   cond_base = rz;
            2'b10:   cond_base = rn;
            default: cond_base = rn | rz;
        endcase
        br_taken = ir[13] ? ~cond_base : cond_base;
    end

    // State register; en=0 freezes the sequencer in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= S_RST;
        end else if (en) begin
            cur_state <= nxt_state;
        end
    end

    // Next-state and raw Moore outputs decoded from the current state.
    always_comb begin
        nxt_state    = S_RST;
        ld_ir_raw    = 1'b0;
        ld_rdir_raw  = 1'b0;
        ld_pc_raw    = 1'b0;
        mem_w_raw    = 1'b0;
        erd_raw      = 1'b0;
        ld_ra_raw    = 1'b0;
        ld_rz_raw    = 1'b0;
        ld_rn_raw    = 1'b0;
        ld_rv_raw    = 1'b0;
        done_raw     = 1'b0;
        mux_1_pc     = 1'b0;
        reset_pc_sel = 1'b0;
        operar_alu   = 1'b0;
        sel_rf       = 2'b01;
        case (cur_state)
            S_RST: begin
                reset_pc_sel = 1'b1;
                ld_pc_raw    = 1'b1;
                nxt_state    = S_FETCH;
            end
            S_FETCH: begin
                ld_ir_raw = 1'b1;
                ld_pc_raw = 1'b1;
                nxt_state = S_DECODE;
            end
            S_DECODE: begin
                sel_rf      = 2'b01;
                ld_rdir_raw = 1'b1;
                ld_ra_raw   = 1'b1;
                case (opcode)
                    OP_LOAD:   nxt_state = S_LOAD;
                    OP_STORE:  nxt_state = S_STORE;
                    OP_BRANCH: begin
                        done_raw  = 1'b1;
                        nxt_state = br_taken ? S_FETCH_BR : S_FETCH;
                    end
                    default:   nxt_state = S_ALU;
                endcase
            end
            S_LOAD: begin
                mux_1_pc  = 1'b1;
                erd_raw   = 1'b1;
                ld_rz_raw = 1'b1;
                ld_rn_raw = 1'b1;
                done_raw  = 1'b1;
                nxt_state = S_FETCH;
            end
            S_STORE: begin
                mux_1_pc  = 1'b1;
                sel_rf    = 2'b00;
                mem_w_raw = 1'b1;
                done_raw  = 1'b1;
                nxt_state = S_FETCH;
            end
            S_ALU: begin
                sel_rf     = 2'b10;
                operar_alu = 1'b1;
                erd_raw    = 1'b1;
                ld_rz_raw  = 1'b1;
                ld_rn_raw  = 1'b1;
                ld_rv_raw  = 1'b1;
                done_raw   = 1'b1;
                nxt_state  = S_FETCH;
            end
            S_FETCH_BR: begin
                mux_1_pc  = 1'b1;
                ld_ir_raw = 1'b1;
                ld_pc_raw = 1'b1;
                nxt_state = S_DECODE;
            end
            default: nxt_state = S_RST;
        endcase
    end

    // Write/load strobes only fire while running; ld_pc also drops with rst_n.
    assign ld_ir      = ld_ir_raw   & en;
    assign ld_rdir    = ld_rdir_raw & en;
    assign ld_pc      = ld_pc_raw   & en & rst_n;
    assign mem_w      = mem_w_raw   & en;
    assign erd        = erd_raw     & en;
    assign ld_ra      = ld_ra_raw   & en;
    assign ld_rz      = ld_rz_raw   & en;
    assign ld_rn      = ld_rn_raw   & en;
    assign ld_rv      = ld_rv_raw   & en;
    assign instr_done = done_raw    & en;

    // Retired-instruction counter, wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_count <= 16'h0000;
        end else if (instr_done) begin
            instr_count <= instr_count + 16'h0001;
        end
    end

endmodule

// File: tb/tb_mr_control_unit.sv
// Directed testbench for mr_control_unit.
module tb_mr_control_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [15:0] ir;
    logic        rz, rn, rv;
    logic        ld_ir, ld_rdir, ld_pc, mux_1_pc, reset_pc_sel, mem_w, erd;
    logic        ld_ra, operar_alu, ld_rz, ld_rn, ld_rv, instr_done;
    logic [1:0]  sel_rf;
    logic [15:0] instr_count;
    logic [2:0]  state;

    int tests = 0;
    int fails = 0;

    mr_control_unit dut (
        .clk(clk), .rst_n(rst_n), .en(en), .ir(ir),
        .rz(rz), .rn(rn), .rv(rv),
        .ld_ir(ld_ir), .ld_rdir(ld_rdir), .ld_pc(ld_pc), .mux_1_pc(mux_1_pc),
        .reset_pc_sel(reset_pc_sel), .mem_w(mem_w), .erd(erd), .ld_ra(ld_ra),
        .operar_alu(operar_alu), .ld_rz(ld_rz), .ld_rn(ld_rn), .ld_rv(ld_rv),
        .sel_rf(sel_rf), .instr_done(instr_done), .instr_count(instr_count),
        .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle 2ns before driving/sampling.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; ir = 16'h0000; rz = 1'b0; rn = 1'b0; rv = 1'b0;
        #2;
        chk("rst_state", {13'd0, state}, 16'd0);
        chk("rst_count", instr_count, 16'h0000);
        chk("rst_pcsel", {15'd0, reset_pc_sel}, 16'd1);
        chk("rst_ldpc_gated", {15'd0, ld_pc}, 16'd0);
        chk("rst_ldir", {15'd0, ld_ir}, 16'd0);

        // First active cycle executes RST.
        #1 rst_n = 1'b1;
        #1;
        chk("rstcyc_ldpc", {15'd0, ld_pc}, 16'd1);
        chk("rstcyc_pcsel", {15'd0, reset_pc_sel}, 16'd1);
        tick();
        chk("fetch_state", {13'd0, state}, 16'd1);
        chk("fetch_mux", {15'd0, mux_1_pc}, 16'd0);
        chk("fetch_ldir", {15'd0, ld_ir}, 16'd1);
        chk("fetch_ldpc", {15'd0, ld_pc}, 16'd1);

        // LOAD 0x0A05
        ir = 16'h0A05;
        tick(); #1;
        chk("ld_dec_state", {13'd0, state}, 16'd2);
        chk("ld_dec_sel", {14'd0, sel_rf}, 16'd1);
        chk("ld_dec_rdir", {15'd0, ld_rdir}, 16'd1);
        chk("ld_dec_ra", {15'd0, ld_ra}, 16'd1);
        chk("ld_dec_done", {15'd0, instr_done}, 16'd0);
        tick();
        chk("ld_state", {13'd0, state}, 16'd3);
        chk("ld_mux", {15'd0, mux_1_pc}, 16'd1);
        chk("ld_erd", {15'd0, erd}, 16'd1);
        chk("ld_flags", {13'd0, ld_rz, ld_rn, ld_rv}, 16'b110);
        chk("ld_opalu", {15'd0, operar_alu}, 16'd0);
        chk("ld_done", {15'd0, instr_done}, 16'd1);
        tick();
        chk("ld_back_fetch", {13'd0, state}, 16'd1);
        chk("ld_count", instr_count, 16'd1);

        // STORE 0x4A05
        ir = 16'h4A05;
        tick(); tick();
        chk("st_state", {13'd0, state}, 16'd4);
        chk("st_memw", {15'd0, mem_w}, 16'd1);
        chk("st_sel", {14'd0, sel_rf}, 16'd0);
        chk("st_mux", {15'd0, mux_1_pc}, 16'd1);
        chk("st_erd", {15'd0, erd}, 16'd0);
        tick();
        chk("st_back_fetch", {13'd0, state}, 16'd1);
        chk("st_count", instr_count, 16'd2);

        // ALU register 0xC044, with a 3-cycle stall in the ALU state.
        ir = 16'hC044;
        tick(); tick();
        chk("alu_state", {13'd0, state}, 16'd5);
        chk("alu_sel", {14'd0, sel_rf}, 16'd2);
        chk("alu_op", {15'd0, operar_alu}, 16'd1);
        chk("alu_erd", {15'd0, erd}, 16'd1);
        chk("alu_flags", {13'd0, ld_rz, ld_rn, ld_rv}, 16'b111);
        en = 1'b0;
        #1;
        chk("stall_erd", {15'd0, erd}, 16'd0);
        chk("stall_flags", {13'd0, ld_rz, ld_rn, ld_rv}, 16'd0);
        chk("stall_done", {15'd0, instr_done}, 16'd0);
        chk("stall_sel", {14'd0, sel_rf}, 16'd2);
        chk("stall_op", {15'd0, operar_alu}, 16'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_hold", {13'd0, state}, 16'd5);
            chk("stall_count", instr_count, 16'd2);
        end
        en = 1'b1;
        #1;
        chk("resume_erd", {15'd0, erd}, 16'd1);
        tick();
        chk("resume_fetch", {13'd0, state}, 16'd1);
        chk("alu_count", instr_count, 16'd3);

        // BEQ taken
        ir = 16'h8810; rz = 1'b1;
        tick();
        chk("beq_dec_done", {15'd0, instr_done}, 16'd1);
        tick();
        chk("beq_fetchbr", {13'd0, state}, 16'd6);
        chk("fbr_mux", {15'd0, mux_1_pc}, 16'd1);
        chk("fbr_ldir", {15'd0, ld_ir}, 16'd1);
        chk("fbr_ldpc", {15'd0, ld_pc}, 16'd1);
        chk("beq_count", instr_count, 16'd4);
        tick();
        chk("fbr_to_dec", {13'd0, state}, 16'd2);

        // Same BEQ, Z clear: not taken
        rz = 1'b0;
        tick();
        chk("beq_nt", {13'd0, state}, 16'd1);
        chk("beq_nt_count", instr_count, 16'd5);

        // cond 100: never, even with flags set
        ir = 16'hA010; rz = 1'b1; rn = 1'b1;
        tick(); tick();
        chk("never_nt", {13'd0, state}, 16'd1);

        // Asynchronous reset in the middle of a STORE
        ir = 16'h4A05; rz = 1'b0; rn = 1'b0;
        tick(); tick();
        chk("st2_memw", {15'd0, mem_w}, 16'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_memw", {15'd0, mem_w}, 16'd0);
        chk("arst_state", {13'd0, state}, 16'd0);
        chk("arst_count", instr_count, 16'd0);

        // Counter wrap from 0xFFFF
        rst_n = 1'b1;
        ir = 16'hA000;
        tick();
        chk("wrap_fetch", {13'd0, state}, 16'd1);
        dut.instr_count = 16'hFFFF;
        tick();
        chk("wrap_pre", instr_count, 16'hFFFF);
        chk("wrap_done", {15'd0, instr_done}, 16'd1);
        tick();
        chk("wrap_count", instr_count, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
